// File: rtl/multibyte_add_seq_if.sv
// Handshake bundle for the byte-serial multi-precision adder.
// master drives operands and out_ready; slave is the adder itself.
`timescale 1ns/1ps

interface multibyte_add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf
    );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: NBYTES-wide a+b+cin through one 8-bit ripple adder.
// Ports: clk, rst_n (async low), bus (slave: in_* accept, out_* result).
`timescale 1ns/1ps

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int k = 0; k < 8; k++) begin
            sum[k] = a[k] ^ b[k] ^ c;
            c      = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        cout = c;
    end
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multibyte_add_seq_if.slave  bus
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t                  state;
    logic [NBYTES-1:0][7:0]  a_reg;
    logic [NBYTES-1:0][7:0]  b_reg;
    logic [NBYTES-1:0][7:0]  acc;
    logic [NBYTES-1:0][7:0]  nxt_acc;
    logic                    carry_reg;
    logic [IW-1:0]           idx;

    logic [7:0]              s;
    logic                    co;
    logic                    last;
    logic                    msb_c;

    adder_8bit u_add (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry_reg),
        .sum  (s),
        .cout (co)
    );

    assign last = (idx == IW'(NBYTES - 1));

    // Carry into the sign bit, recovered from the top byte's sum bit.
    assign msb_c = a_reg[NBYTES-1][7] ^ b_reg[NBYTES-1][7] ^ s[7];

    always_comb begin
        nxt_acc      = acc;
        nxt_acc[idx] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            carry_reg     <= 1'b0;
            idx           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.in_a;
                        b_reg        <= bus.in_b;
                        carry_reg    <= bus.in_cin;
                        idx          <= '0;
                        acc          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= ADD;
                    end
                end
                ADD: begin
                    acc       <= nxt_acc;
                    carry_reg <= co;
                    if (last) begin
                        // Index parks at NBYTES-1; cleared on next accept.
                        bus.out_sum   <= nxt_acc;
                        bus.out_cout  <= co;
                        bus.out_ovf   <= msb_c ^ co;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
